// File: rtl/bf16_pkg.sv
// Shared BF16 definitions: field widths, special encodings, per-lane flags and operand classification.
package bf16_pkg;

    localparam int BF16_W = 16;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 7;
    localparam int BIAS   = 127;

    localparam logic [BF16_W-1:0] QNAN    = 16'h7FC0;
    localparam logic [BF16_W-1:0] POS_INF = 16'h7F80;

    typedef logic [BF16_W-1:0] bf16_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } bf16_flags_t;

    // Result class decided in S1; it selects the special-case override applied in S3.
    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } bf16_cls_t;

    // Subnormals (e=0, m!=0) classify as zero so they are flushed before the multiply.
    function automatic bf16_cls_t classify(input bf16_t x);
        bf16_cls_t cls;
        if (&x[BF16_W-2 -: EXP_W]) begin
            cls = (|x[MAN_W-1:0]) ? CLS_NAN : CLS_INF;
        end else if (x[BF16_W-2 -: EXP_W] == '0) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/bf16_mult_lane.sv
// One BF16 multiply lane: S1 unpack/multiply, S2 normalise/round, S3 pack/override into output registers.
module bf16_mult_lane
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s1_en_i,
    input  logic        s2_en_i,
    input  logic        s3_en_i,
    input  bf16_t       a_i,
    input  bf16_t       b_i,
    input  logic        trunc_i,
    output bf16_t       prod_o,
    output bf16_flags_t flags_o
);

    bf16_cls_t          cls_a, cls_b;
    logic               s1_sign_d, s1_sign_q;
    bf16_cls_t          s1_cls_d, s1_cls_q;
    logic signed [9:0]  s1_exp_d, s1_exp_q;
    logic [15:0]        s1_prod_d, s1_prod_q;

    always_comb begin
        cls_a     = classify(a_i);
        cls_b     = classify(b_i);
        s1_sign_d = a_i[15] ^ b_i[15];
        s1_exp_d  = $signed({2'b00, a_i[14:7]}) + $signed({2'b00, b_i[14:7]}) - 10'sd127;
        s1_prod_d = {8'h00, 1'b1, a_i[6:0]} * {8'h00, 1'b1, b_i[6:0]};
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            s1_cls_d = CLS_NAN;
        end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                     (cls_b == CLS_INF && cls_a == CLS_ZERO)) begin
            s1_cls_d = CLS_NAN;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            s1_cls_d = CLS_INF;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_cls_d = CLS_NORM;
        end
    end

    logic               norm_hi, guard, sticky, round_up;
    logic [6:0]         man_pre;
    logic [7:0]         man_rnd;
    logic               s2_sign_q;
    bf16_cls_t          s2_cls_q;
    logic signed [9:0]  s2_exp_d, s2_exp_q;
    logic [6:0]         s2_man_q;

    // The 8x8 product of two 1.xxx significands lies in [1,4); bit 15 set means it needs a 1-bit shift.
    always_comb begin
        norm_hi  = s1_prod_q[15];
        man_pre  = norm_hi ? s1_prod_q[14:8] : s1_prod_q[13:7];
        guard    = norm_hi ? s1_prod_q[7]    : s1_prod_q[6];
        sticky   = norm_hi ? (|s1_prod_q[6:0]) : (|s1_prod_q[5:0]);
        round_up = !trunc_i && guard && (sticky || man_pre[0]);
        man_rnd  = {1'b0, man_pre} + {7'b0, round_up};
        s2_exp_d = s1_exp_q + $signed({9'b0, norm_hi}) + $signed({9'b0, man_rnd[7]});
    end

    bf16_t       prod_d, prod_q;
    bf16_flags_t flags_d, flags_q;

    always_comb begin
        flags_d = '0;
        prod_d  = '0;
        case (s2_cls_q)
            CLS_NAN: begin
                prod_d          = QNAN;
                flags_d.invalid = 1'b1;
            end
            CLS_INF:  prod_d = {s2_sign_q, POS_INF[14:0]};
            CLS_ZERO: prod_d = {s2_sign_q, 15'h0};
            default: begin
                if (s2_exp_q >= 10'sd255) begin
                    prod_d           = {s2_sign_q, POS_INF[14:0]};
                    flags_d.overflow = 1'b1;
                end else if (s2_exp_q <= 10'sd0) begin
                    prod_d            = {s2_sign_q, 15'h0};
                    flags_d.underflow = 1'b1;
                end else begin
                    prod_d = {s2_sign_q, s2_exp_q[7:0], s2_man_q};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_q <= 1'b0;
            s1_cls_q  <= CLS_ZERO;
            s1_exp_q  <= '0;
            s1_prod_q <= '0;
            s2_sign_q <= 1'b0;
            s2_cls_q  <= CLS_ZERO;
            s2_exp_q  <= '0;
            s2_man_q  <= '0;
            prod_q    <= '0;
            flags_q   <= '0;
        end else begin
            if (s1_en_i) begin
                s1_sign_q <= s1_sign_d;
                s1_cls_q  <= s1_cls_d;
                s1_exp_q  <= s1_exp_d;
                s1_prod_q <= s1_prod_d;
            end
            if (s2_en_i) begin
                s2_sign_q <= s1_sign_q;
                s2_cls_q  <= s1_cls_q;
                s2_exp_q  <= s2_exp_d;
                s2_man_q  <= man_rnd[6:0];
            end
            if (s3_en_i) begin
                prod_q  <= prod_d;
                flags_q <= flags_d;
            end
        end
    end

    assign prod_o  = prod_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/bf16_mult_pipe.sv
// Multi-lane 3-stage BF16 multiplier with valid/ready flow control; tag and rounding mode ride with each beat.
module bf16_mult_pipe
    import bf16_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAG_W     = 8
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*NUM_LANES-1:0] in_A,
    input  logic [16*NUM_LANES-1:0] in_B,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    rnd_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*NUM_LANES-1:0] out_O,
    output logic [TAG_W-1:0]        out_tag,
    output logic [3*NUM_LANES-1:0]  out_flags
);

    logic             v1_q, v2_q, v3_q;
    logic             v1_d, v2_d, v3_d;
    logic             rdy1, rdy2, rdy3;
    logic             ld1, ld2, ld3;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic             mode1_q;

    // A stage may load whenever it is empty or its content moves on this cycle, so bubbles collapse.
    always_comb begin
        rdy3 = out_ready || !v3_q;
        rdy2 = !v2_q || rdy3;
        rdy1 = !v1_q || rdy2;
        ld1  = rdy1 && in_valid;
        ld2  = rdy2 && v1_q;
        ld3  = rdy3 && v2_q;
        v1_d = rdy1 ? in_valid : v1_q;
        v2_d = rdy2 ? v1_q     : v2_q;
        v3_d = rdy3 ? v2_q     : v3_q;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            mode1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (ld1) begin
                tag1_q  <= in_tag;
                mode1_q <= rnd_mode;
            end
            if (ld2) tag2_q <= tag1_q;
            if (ld3) tag3_q <= tag2_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            bf16_mult_lane u_lane (
                .clk     (CLK),
                .rst_n   (rst_n),
                .s1_en_i (ld1),
                .s2_en_i (ld2),
                .s3_en_i (ld3),
                .a_i     (in_A[16*gi +: 16]),
                .b_i     (in_B[16*gi +: 16]),
                .trunc_i (mode1_q),
                .prod_o  (out_O[16*gi +: 16]),
                .flags_o (out_flags[3*gi +: 3])
            );
        end
    endgenerate

    assign in_ready  = rdy1;
    assign out_valid = v3_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_bf16_mult_pipe.sv
// Scoreboard bench for bf16_mult_pipe: directed vectors plus random beats checked against a real-arithmetic model.
module tb_bf16_mult_pipe;

    localparam int NL = 4;
    localparam int TW = 8;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [16*NL-1:0] in_A, in_B;
    logic [TW-1:0]   in_tag;
    logic            rnd_mode;
    logic            out_valid;
    logic            out_ready;
    logic [16*NL-1:0] out_O;
    logic [TW-1:0]   out_tag;
    logic [3*NL-1:0] out_flags;

    bf16_mult_pipe #(.NUM_LANES(NL), .TAG_W(TW)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_tag    (in_tag),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_O     (out_O),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic [16*NL-1:0] o;
        logic [TW-1:0]    tag;
        logic [3*NL-1:0]  fl;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t            sb[$];
    int              total = 0;
    int              bad = 0;
    int              cyc = 0;
    bit              rand_ready = 1'b0;
    logic            ready_val = 1'b1;
    bit              prev_stall = 1'b0;
    logic [16*NL-1:0] prev_o;
    logic [TW-1:0]   prev_tag;
    logic [3*NL-1:0] prev_fl;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endfunction

    // Value-level model: decode both operands, multiply as reals (exact), re-round the double to 7 mantissa bits.
    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b, input logic mode,
                                    output logic [15:0] o, output logic [2:0] fl);
        int ea, eb, ma, mb, e, m;
        bit s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, up;
        real va, vb, p;
        logic [63:0] bits;
        logic [6:0]  keep;
        logic [44:0] rest;
        s  = a[15] ^ b[15];
        ea = int'(a[14:7]);  eb = int'(b[14:7]);
        ma = int'(a[6:0]);   mb = int'(b[6:0]);
        nan_a  = (ea == 255) && (ma != 0);  nan_b  = (eb == 255) && (mb != 0);
        inf_a  = (ea == 255) && (ma == 0);  inf_b  = (eb == 255) && (mb == 0);
        zero_a = (ea == 0);                 zero_b = (eb == 0);
        fl = 3'b000;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            o = 16'h7FC0; fl = 3'b100; return;
        end
        if (inf_a || inf_b) begin o = {s, 15'h7F80}; return; end
        if (zero_a || zero_b) begin o = {s, 15'h0}; return; end
        va = (128.0 + real'(ma)) / 128.0 * (2.0 ** (ea - 127));
        vb = (128.0 + real'(mb)) / 128.0 * (2.0 ** (eb - 127));
        p  = va * vb;
        bits = $realtobits(p);
        e    = int'(bits[62:52]) - 1023 + 127;
        keep = bits[51:45];
        rest = bits[44:0];
        up   = (mode == 1'b0) && ((rest > 45'h1000_0000_0000) || (rest == 45'h1000_0000_0000 && keep[0]));
        m    = int'(keep) + (up ? 1 : 0);
        if (m == 128) begin m = 0; e++; end
        if (e >= 255)     begin o = {s, 15'h7F80}; fl = 3'b010; end
        else if (e <= 0)  begin o = {s, 15'h0};    fl = 3'b001; end
        else              o = {s, e[7:0], m[6:0]};
    endfunction

    function automatic void model_beat(input logic [16*NL-1:0] a, input logic [16*NL-1:0] b, input logic mode,
                                       output logic [16*NL-1:0] eo, output logic [3*NL-1:0] ef);
        logic [15:0] o;
        logic [2:0]  f;
        eo = '0;
        ef = '0;
        for (int i = 0; i < NL; i++) begin
            ref_mul(a[16*i +: 16], b[16*i +: 16], mode, o, f);
            eo[16*i +: 16] = o;
            ef[3*i +: 3]   = f;
        end
    endfunction

    function automatic logic [15:0] rnd_normal();
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
        s = 1'($urandom_range(0, 1));
        m = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(1, 254));
        else                           e = 8'($urandom_range(100, 154));
        return {s, e, m};
    endfunction

    function automatic logic [15:0] rnd_any();
        logic [15:0] v;
        v = rnd_normal();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 5))
                0:       v = 16'h0000;
                1:       v = 16'h8000;
                2:       v = 16'h7F80;
                3:       v = 16'hFF80;
                4:       v = {9'h0FF, 7'($urandom_range(1, 127))};
                default: v = {9'h000, 7'($urandom_range(1, 127))};
            endcase
        end
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [16*NL-1:0] a, input logic [16*NL-1:0] b, input logic [TW-1:0] tag,
                        input logic mode, input logic [16*NL-1:0] eo, input logic [3*NL-1:0] ef, input bit lat);
        exp_t e;
        int   n;
        in_A = a; in_B = b; in_tag = tag; rnd_mode = mode; in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge CLK);
            if (in_ready) begin
                e.o = eo; e.tag = tag; e.fl = ef; e.acc = cyc; e.lat = lat;
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                fail_now("in_ready_timeout");
                break;
            end
            @(posedge CLK); #1;
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [TW-1:0] tag, input bit specials);
        logic [16*NL-1:0] a, b, eo;
        logic [3*NL-1:0]  ef;
        logic             mode;
        for (int i = 0; i < NL; i++) begin
            a[16*i +: 16] = specials ? rnd_any() : rnd_normal();
            b[16*i +: 16] = specials ? rnd_any() : rnd_normal();
        end
        mode = 1'($urandom_range(0, 1));
        model_beat(a, b, mode, eo, ef);
        send(a, b, tag, mode, eo, ef, 1'b0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; in_tag = '0; rnd_mode = 1'b0; out_ready = 1'b1;

        fork
            forever begin
                @(posedge CLK);
                cyc++;
            end
            forever begin
                @(posedge CLK); #2;
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
            end
            forever begin : monitor
                exp_t e;
                @(negedge CLK);
                if (!rst_n) begin
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        check("hold_valid", 64'(out_valid), 64'd1);
                        check("hold_O", out_O, prev_o);
                        check("hold_tag", 64'(out_tag), 64'(prev_tag));
                        check("hold_flags", 64'(out_flags), 64'(prev_fl));
                    end
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            fail_now("unexpected_beat");
                        end else begin
                            e = sb.pop_front();
                            $display("beat tag=%h O=%h flags=%h exp_O=%h exp_flags=%h",
                                     out_tag, out_O, out_flags, e.o, e.fl);
                            check("O", out_O, e.o);
                            check("tag", 64'(out_tag), 64'(e.tag));
                            check("flags", 64'(out_flags), 64'(e.fl));
                            if (e.lat) check("latency", 64'(cyc - e.acc), 64'd3);
                        end
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_o     = out_O;
                    prev_tag   = out_tag;
                    prev_fl    = out_flags;
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_O", out_O, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        rst_n = 1'b1;
        @(posedge CLK); #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Basic lanes (lane 0 in the low 16 bits)
        send({16'h3FA0, 16'h4480, 16'h4100, 16'h4040}, {16'h4020, 16'h4600, 16'h449B, 16'h3F80}, 8'h01, 1'b0,
             {16'h4048, 16'h4B00, 16'h461B, 16'h4040}, 12'h000, 1'b1);
        // Rounding: tie to even, truncate, carry-free round
        send({16'h3F80, 16'h3F80, 16'h3FFF, 16'h3FC0}, {16'h3F80, 16'h3F80, 16'h3FFF, 16'h3F81}, 8'h02, 1'b0,
             {16'h3F80, 16'h3F80, 16'h407E, 16'h3FC2}, 12'h000, 1'b1);
        send({16'h3F80, 16'h3F80, 16'h3FFF, 16'h3FC0}, {16'h3F80, 16'h3F80, 16'h3FFF, 16'h3F81}, 8'h03, 1'b1,
             {16'h3F80, 16'h3F80, 16'h407E, 16'h3FC1}, 12'h000, 1'b1);
        // Specials: overflow, underflow, Inf*0, subnormal flush; then -1*Inf, signed zero, NaN input
        send({16'h0001, 16'h7F80, 16'h0080, 16'h7F00}, {16'h4000, 16'h0000, 16'h3F00, 16'h4000}, 8'h04, 1'b0,
             {16'h0000, 16'h7FC0, 16'h0000, 16'h7F80}, {3'b000, 3'b100, 3'b001, 3'b010}, 1'b1);
        send({16'h3F80, 16'hFFC1, 16'h8000, 16'hBF80}, {16'h3F80, 16'h3F80, 16'h3F80, 16'h7F80}, 8'h05, 1'b0,
             {16'h3F80, 16'h7FC0, 16'h8000, 16'hFF80}, {3'b000, 3'b100, 3'b000, 3'b000}, 1'b1);
        wait_drain();

        // Full pipeline with output stalled
        ready_val = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) send_model(8'(8'hA0 + i), 1'b0);
        @(negedge CLK);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge CLK); #1;
        ready_val = 1'b1;
        wait_drain();

        // Random backpressure stream, tags 0..9
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_model(8'(i), 1'b0);
        rand_ready = 1'b0;
        wait_drain();

        // Reset with three beats in flight
        ready_val = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) send_model(8'(8'hB0 + i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_O", out_O, 64'd0);
        sb.delete();
        ready_val = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        check("no_stale_valid", 64'(out_valid), 64'd0);
        send({16'h3FA0, 16'h4480, 16'h4100, 16'h4040}, {16'h4020, 16'h4600, 16'h449B, 16'h3F80}, 8'hC0, 1'b0,
             {16'h4048, 16'h4B00, 16'h461B, 16'h4040}, 12'h000, 1'b1);
        wait_drain();

        // Random lanes, both modes, random bubbles and backpressure; then a mix with specials
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
            send_model(8'(i), 1'b0);
        end
        for (int i = 0; i < 200; i++) send_model(8'(i), 1'b1);
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        wait_drain();

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
